// File: rtl/celement_token_scheduler_if.sv
// rtl/celement_token_scheduler_if.sv - requester and self-timed stage handshake bundle
interface celement_token_scheduler_if #(
   parameter int NREQ = 4
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] exbreq;
   logic            halt;
   logic            sendout;
   logic            exbout;
   logic            ackin;
   logic            lopen;
   logic [NREQ-1:0] gnt;
   logic [GW-1:0]   grantid;
   logic            busy;
   logic            timeout_err;

   modport master (
      output req, exbreq, halt, ackin,
      input  sendout, exbout, lopen, gnt, grantid, busy, timeout_err
   );

   modport slave (
      input  req, exbreq, halt, ackin,
      output sendout, exbout, lopen, gnt, grantid, busy, timeout_err
   );
endinterface

// File: rtl/celement_token_scheduler.sv
// rtl/celement_token_scheduler.sv - round-robin four-phase scheduler into a C-element stage
module celement_token_scheduler #(
   parameter int NREQ        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input logic clk,
   input logic reset,
   celement_token_scheduler_if.slave bus
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETUP   = 3'd1;
   localparam logic [2:0] S_SEND    = 3'd2;
   localparam logic [2:0] S_RELEASE = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
   localparam logic [2:0] S_FAULT   = 3'd5;

   logic [2:0]             state;
   logic [2:0]             state_n;
   logic [GW-1:0]          ptr;
   logic [GW-1:0]          grantid;
   logic [GW-1:0]          winner;
   logic                   found;
   int                     k;
   logic                   exbout;
   logic                   sendout;
   logic                   rst_q;
   logic [CW-1:0]          cnt;
   logic                   tmo;
   logic [SYNC_STAGES-1:0] sync;
   logic                   ack;
   logic [NREQ-1:0]        gnt;

   // The stage acknowledge is asynchronous; only the last flop may reach the FSM.
   always_ff @(posedge clk) begin
      if (reset) sync <= '0;
      else       sync <= {sync[SYNC_STAGES-2:0], bus.ackin};
   end
   assign ack = sync[SYNC_STAGES-1];

   always_comb begin
      winner = '0;
      found  = 1'b0;
      k      = 0;
      for (int i = 0; i < NREQ; i++) begin
         k = int'(ptr) + i;
         if (k >= NREQ) k = k - NREQ;
         if (!found && bus.req[k]) begin
            found  = 1'b1;
            winner = GW'(k);
         end
      end
   end

   assign tmo = (cnt == CW'(TIMEOUT_CYC));

   // An acknowledge arriving on the timeout cycle still completes the phase.
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (!bus.halt && found) state_n = S_SETUP;
         S_SETUP:   state_n = S_SEND;
         S_SEND:    if (ack) state_n = S_RELEASE;
                    else if (tmo) state_n = S_FAULT;
         S_RELEASE: if (!ack) state_n = S_DONE;
                    else if (tmo) state_n = S_FAULT;
         S_DONE:    state_n = S_IDLE;
         S_FAULT:   state_n = S_FAULT;
         default:   state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         ptr     <= '0;
         grantid <= '0;
         exbout  <= 1'b0;
         sendout <= 1'b0;
         cnt     <= '0;
         rst_q   <= 1'b1;
      end else begin
         rst_q   <= 1'b0;
         state   <= state_n;
         sendout <= (state_n == S_SEND);
         if (state == S_IDLE && state_n == S_SETUP) begin
            grantid <= winner;
            exbout  <= bus.exbreq[winner];
         end
         if (state == S_DONE)
            ptr <= (grantid == GW'(NREQ - 1)) ? '0 : grantid + 1'b1;
         if (state_n != state)
            cnt <= '0;
         else if (state == S_SEND || state == S_RELEASE)
            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      gnt = '0;
      if (state == S_DONE) gnt[grantid] = 1'b1;
   end

   // rst_q keeps the loop open for the cycle right after reset, before HALT governs it.
   assign bus.lopen       = rst_q || (state == S_FAULT) || (state == S_IDLE && bus.halt);
   assign bus.sendout     = sendout;
   assign bus.exbout      = exbout;
   assign bus.grantid     = grantid;
   assign bus.gnt         = gnt;
   assign bus.busy        = (state == S_SETUP) || (state == S_SEND) ||
                            (state == S_RELEASE) || (state == S_DONE);
   assign bus.timeout_err = (state == S_FAULT);
endmodule

// File: tb/tb_celement_token_scheduler.sv
// tb/tb_celement_token_scheduler.sv - directed self-checking bench for celement_token_scheduler
module tb_celement_token_scheduler;
   logic clk = 1'b0;
   logic reset = 1'b1;
   bit   echo = 1'b0;
   int   checks = 0;
   int   failures = 0;

   celement_token_scheduler_if #(.NREQ(4)) bus();

   celement_token_scheduler #(
      .NREQ(4), .SYNC_STAGES(2), .TIMEOUT_CYC(15)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Stage model: ACKIN follows SENDOUT half a cycle later.
   always @(negedge clk) if (echo) bus.ackin = bus.sendout;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset = 1'b1;
      echo = 1'b0;
      bus.req = '0;
      bus.exbreq = '0;
      bus.halt = 1'b0;
      bus.ackin = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic wait_gnt(output logic [3:0] g, output bit ok);
      ok = 1'b0;
      g = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.gnt !== 4'b0000) begin
            g = bus.gnt;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_sendout(input logic lvl, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.sendout === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.req = 4'b1111;
      bus.exbreq = 4'b1111;
      bus.halt = 1'b0;
      bus.ackin = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.sendout !== 1'b0) begin failures++; $display("FAIL reset_sendout got=%0b exp=0", bus.sendout); end
      checks++; if (bus.exbout !== 1'b0) begin failures++; $display("FAIL reset_exbout got=%0b exp=0", bus.exbout); end
      checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
      checks++; if (bus.grantid !== 2'd0) begin failures++; $display("FAIL reset_grantid got=%0d exp=0", bus.grantid); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
      checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err got=%0b exp=0", bus.timeout_err); end
      checks++; if (bus.lopen !== 1'b1) begin failures++; $display("FAIL reset_lopen got=%0b exp=1", bus.lopen); end
   endtask

   task automatic test_single();
      logic [3:0] g;
      bit ok;
      int hi;
      do_reset();
      echo = 1'b1;
      bus.exbreq = 4'b0001;
      bus.req = 4'b0001;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b1 || bus.sendout !== 1'b0) begin failures++; $display("FAIL single_setup got busy=%0b sendout=%0b exp busy=1 sendout=0", bus.busy, bus.sendout); end
      @(negedge clk);
      checks++; if (bus.sendout !== 1'b1 || bus.exbout !== 1'b1) begin failures++; $display("FAIL single_send got sendout=%0b exbout=%0b exp 1 1", bus.sendout, bus.exbout); end
      hi = 0;
      for (int i = 0; i < 30; i++) begin
         if (bus.sendout !== 1'b1) break;
         hi++;
         @(negedge clk);
      end
      checks++; if (hi != 3) begin failures++; $display("FAIL single_send_len got=%0d exp=3", hi); end
      wait_gnt(g, ok);
      checks++; if (!ok || g !== 4'b0001 || bus.grantid !== 2'd0) begin failures++; $display("FAIL single_gnt got gnt=%b id=%0d ok=%0b exp gnt=0001 id=0", g, bus.grantid, ok); end
      bus.req = 4'b0000;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.exbout !== 1'b1) begin failures++; $display("FAIL single_idle got busy=%0b gnt=%b exbout=%0b exp 0 0000 1", bus.busy, bus.gnt, bus.exbout); end
   endtask

   task automatic test_round_robin();
      int exp_id[5]  = '{0, 1, 2, 3, 0};
      int exp_exb[5] = '{0, 1, 0, 1, 0};
      logic [3:0] g;
      logic exb_seen;
      bit ok, ok2;
      do_reset();
      echo = 1'b1;
      bus.exbreq = 4'b1010;
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_sendout(1'b1, ok);
         exb_seen = bus.exbout;
         wait_gnt(g, ok2);
         checks++;
         if (!ok || !ok2 || g !== (4'b0001 << exp_id[n]) || bus.grantid !== 2'(exp_id[n]) || exb_seen !== 1'(exp_exb[n])) begin
            failures++;
            $display("FAIL rr_grant%0d got gnt=%b id=%0d exb=%0b exp id=%0d exb=%0d", n, g, bus.grantid, exb_seen, exp_id[n], exp_exb[n]);
         end
      end
      bus.req = 4'b0000;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok;
      bit gs;
      int hi, bad;
      do_reset();
      bus.exbreq = 4'b0001;
      bus.req = 4'b0001;
      wait_sendout(1'b1, ok);
      hi = 0;
      gs = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.gnt !== 4'b0000) gs = 1'b1;
         if (bus.sendout !== 1'b1) break;
         hi++;
         @(negedge clk);
      end
      checks++; if (!ok || hi != 16) begin failures++; $display("FAIL timeout_send_len got=%0d exp=16", hi); end
      checks++; if (bus.timeout_err !== 1'b1 || bus.lopen !== 1'b1 || bus.busy !== 1'b0 || gs) begin failures++; $display("FAIL timeout_flags got err=%0b lopen=%0b busy=%0b gnt_seen=%0b exp 1 1 0 0", bus.timeout_err, bus.lopen, bus.busy, gs); end
      bus.req = 4'b1111;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.sendout !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.timeout_err !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL timeout_sticky got bad_cycles=%0d exp=0", bad); end
      do_reset();
      @(negedge clk);
      checks++; if (bus.timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%0b exp=0", bus.timeout_err); end
   endtask

   task automatic test_halt();
      logic [3:0] g;
      bit ok;
      int bad;
      do_reset();
      echo = 1'b1;
      bus.req = 4'b0011;
      wait_sendout(1'b1, ok);
      bus.halt = 1'b1;
      wait_gnt(g, ok);
      checks++; if (!ok || g !== 4'b0001) begin failures++; $display("FAIL halt_complete got=%b exp=0001", g); end
      bus.req = 4'b0010;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.busy !== 1'b0 || bus.lopen !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL halt_blocks got bad_cycles=%0d exp=0", bad); end
      bus.halt = 1'b0;
      #1;
      checks++; if (bus.lopen !== 1'b0) begin failures++; $display("FAIL halt_lopen_release got=%0b exp=0", bus.lopen); end
      wait_gnt(g, ok);
      checks++; if (!ok || g !== 4'b0010) begin failures++; $display("FAIL halt_resume got=%b exp=0010", g); end
      bus.req = 4'b0000;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [3:0] g;
      bit ok;
      do_reset();
      echo = 1'b1;
      bus.req = 4'b0001;
      wait_gnt(g, ok);
      bus.req = 4'b0010;
      wait_sendout(1'b1, ok);
      wait_sendout(1'b0, ok);
      echo = 1'b0;
      bus.ackin = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (!ok || bus.sendout !== 1'b0 || bus.lopen !== 1'b1 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.grantid !== 2'd0) begin
         failures++;
         $display("FAIL midreset_outputs got sendout=%0b lopen=%0b busy=%0b gnt=%b id=%0d exp 0 1 0 0000 0", bus.sendout, bus.lopen, bus.busy, bus.gnt, bus.grantid);
      end
      bus.ackin = 1'b0;
      bus.req = 4'b0101;
      @(negedge clk);
      reset = 1'b0;
      echo = 1'b1;
      wait_gnt(g, ok);
      checks++; if (!ok || g !== 4'b0001) begin failures++; $display("FAIL midreset_ptr got=%b exp=0001", g); end
      bus.req = 4'b0100;
      wait_gnt(g, ok);
      checks++; if (!ok || g !== 4'b0100 || bus.grantid !== 2'd2) begin failures++; $display("FAIL midreset_idx2 got gnt=%b id=%0d exp 0100 2", g, bus.grantid); end
      bus.req = 4'b0000;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_glitch();
      bit ok;
      int xc, gc;
      do_reset();
      bus.exbreq = 4'b0001;
      bus.req = 4'b0001;
      wait_sendout(1'b1, ok);
      #3 bus.ackin = 1'b1;
      #3 bus.ackin = 1'b0;
      xc = 0;
      gc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if ($isunknown({bus.sendout, bus.gnt, bus.busy, bus.lopen, bus.exbout, bus.timeout_err})) xc++;
         if (bus.gnt !== 4'b0000) gc++;
      end
      checks++; if (!ok || xc != 0) begin failures++; $display("FAIL glitch_no_x got x_cycles=%0d exp=0", xc); end
      checks++; if (gc > 1) begin failures++; $display("FAIL glitch_single got gnt_pulses=%0d exp<=1", gc); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_halt();
      test_reset_mid();
      test_glitch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
